// File: rtl/mips_bus_ram_model.sv
// mips_bus_ram_model: Avalon-style word memory serving mips_cpu_bus in CPU benches.
// Fixed wait states per transfer, selectable byte-lane ordering, sticky error
// flag for illegal accesses, and completed-transfer counters.
// Optional macro RAM_MODEL_RANDOM_WAIT_EN: per-transfer wait count drawn from a
// 16-bit LFSR instead of the fixed WAIT_CYCLES value.
module mips_bus_ram_model #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter bit          BIG_ENDIAN  = 1'b1,
  parameter string       INIT_FILE   = "ram.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic {IDLE, STALL} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  limit_q;
  logic [31:0] readdata_q, readdata_d;
  logic        err_q, err_d;
  logic [31:0] rd_count_q, wr_count_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] idx;
  logic [AW-1:0] widx;
  logic        inRange;
  logic        misaligned;
  logic        addrZero;
  logic        request;
  logic        waitReq;
  logic        accept;
  logic        doWrite;
  logic        doRead;
  logic        errSet;
  logic [3:0]  waitLimitNew;
  logic [31:0] memWord;

  // Storage byte that a given bus lane maps onto.
  function automatic int laneOf(input int lane);
    return BIG_ENDIAN ? (3 - lane) : lane;
  endfunction

  assign idx        = (address - BASE_ADDR) >> 2;
  assign widx       = idx[AW-1:0];
  assign inRange    = idx < 32'(DEPTH_WORDS);
  assign misaligned = address[1:0] != 2'b00;
  assign addrZero   = address == 32'h0;
  assign request    = read | write;
  assign memWord    = mem_q[widx];

`ifdef RAM_MODEL_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  logic        lfsrFb;

  assign lfsrFb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign waitLimitNew = 4'(int'(lfsr_q[3:0]) % (WAIT_CYCLES + 1));

  // LFSR steps once per accepted transfer so each transfer gets a fresh wait count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[14:0], lfsrFb};
    end
  end
`else
  assign waitLimitNew = 4'(WAIT_CYCLES);
`endif

  // Stall decision: a fresh request in IDLE stalls if any wait is due; in STALL
  // the counter runs until it reaches the limit sampled on arrival.
  always_comb begin
    waitReq = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE:    waitReq = request && (waitLimitNew != 4'd0);
        STALL:   waitReq = cnt_q < limit_q;
        default: waitReq = 1'b0;
      endcase
    end
  end

  assign waitrequest = waitReq;
  assign accept      = request & ~waitReq & ~reset;
  assign doWrite     = accept & write;
  assign doRead      = accept & read & ~write;
  assign errSet      = (read & write) | misaligned | (~inRange & ~(read & ~write & addrZero));

  // Next read data and error flag for an accepting edge; disabled lanes hold.
  always_comb begin
    readdata_d = readdata_q;
    err_d      = err_q;
    if (doRead) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          if (addrZero || !inRange) readdata_d[8*i +: 8] = 8'h00;
          else readdata_d[8*i +: 8] = memWord[8*laneOf(i) +: 8];
        end
      end
    end
    if (accept && errSet) err_d = 1'b1;
  end

  // Transfer FSM with stall counter, registered read data, error flag and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      limit_q    <= 4'd0;
      readdata_q <= 32'h0;
      err_q      <= 1'b0;
      rd_count_q <= 32'h0;
      wr_count_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (request && (waitLimitNew != 4'd0)) begin
            cnt_q   <= 4'd1;
            limit_q <= waitLimitNew;
            state_q <= STALL;
          end
        end
        STALL: begin
          if (!request) begin
            cnt_q   <= 4'd0;
            state_q <= IDLE;
          end else if (waitReq) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            cnt_q   <= 4'd0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      readdata_q <= readdata_d;
      err_q      <= err_d;
      if (doRead)  rd_count_q <= rd_count_q + 32'd1;
      if (doWrite) wr_count_q <= wr_count_q + 32'd1;
    end
  end

  // Memory array: enabled lanes of an accepted in-range write, no reset.
  always_ff @(posedge clk) begin
    if (doWrite && inRange) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) mem_q[widx][8*laneOf(i) +: 8] <= writedata[8*i +: 8];
      end
    end
  end

  assign readdata = readdata_q;
  assign err      = err_q;
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mips_bus_ram_model.sv
// Bench for mips_bus_ram_model: a zero-wait big-endian instance driven from a
// vector table, and a three-wait little-endian instance driven by hand-written
// multi-cycle sequences. Expected results go through a scoreboard queue.
module tb_mips_bus_ram_model;

  typedef struct {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] expData;
    logic        expErr;
    logic [31:0] expRd;
    logic [31:0] expWr;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    logic [31:0] rd;
    logic [31:0] wr;
  } exp_t;

  logic clk = 1'b0;

  logic        rstA = 1'b1, aRead = 1'b0, aWrite = 1'b0;
  logic [31:0] aAddr = 32'h0, aWdata = 32'h0;
  logic [3:0]  aBe = 4'h0;
  logic        aWait, aErr;
  logic [31:0] aRdata, aRdCnt, aWrCnt;

  logic        rstB = 1'b1, bRead = 1'b0, bWrite = 1'b0;
  logic [31:0] bAddr = 32'h0, bWdata = 32'h0;
  logic [3:0]  bBe = 4'h0;
  logic        bWait, bErr;
  logic [31:0] bRdata, bRdCnt, bWrCnt;

  int vecCount  = 0;
  int missCount = 0;

  vec_t vecs [26];
  exp_t sbQ [$];

  always #5 clk = ~clk;

  mips_bus_ram_model #(
    .BASE_ADDR(32'hBFC00000), .DEPTH_WORDS(16), .WAIT_CYCLES(0),
    .BIG_ENDIAN(1'b1), .INIT_FILE("")
  ) dutA (
    .clk(clk), .reset(rstA), .address(aAddr), .read(aRead), .write(aWrite),
    .writedata(aWdata), .byteenable(aBe), .waitrequest(aWait), .readdata(aRdata),
    .err(aErr), .rd_count(aRdCnt), .wr_count(aWrCnt)
  );

  mips_bus_ram_model #(
    .BASE_ADDR(32'hBFC00000), .DEPTH_WORDS(16), .WAIT_CYCLES(3),
    .BIG_ENDIAN(1'b0), .INIT_FILE("")
  ) dutB (
    .clk(clk), .reset(rstB), .address(bAddr), .read(bRead), .write(bWrite),
    .writedata(bWdata), .byteenable(bBe), .waitrequest(bWait), .readdata(bRdata),
    .err(bErr), .rd_count(bRdCnt), .wr_count(bWrCnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic popAndCompare(input logic [31:0] data, input logic e,
                               input logic [31:0] rdc, input logic [31:0] wrc);
    exp_t x;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      x = sbQ.pop_front();
      checkOutput({x.tag, "_readdata"}, data, x.data);
      checkOutput({x.tag, "_err"}, {31'd0, e}, {31'd0, x.err});
      checkOutput({x.tag, "_rd_count"}, rdc, x.rd);
      checkOutput({x.tag, "_wr_count"}, wrc, x.wr);
    end
  endtask

  // One zero-wait transfer on instance A, optionally preceded by a reset pulse.
  task automatic applyStimulus(input vec_t v, input int n);
    if (v.rst) begin
      @(negedge clk);
      rstA = 1'b1;
      #2;
      rstA = 1'b0;
    end
    @(negedge clk);
    aRead = v.rd; aWrite = v.wr; aAddr = v.addr; aWdata = v.wdata; aBe = v.be;
    sbQ.push_back('{$sformatf("vec%0d", n), v.expData, v.expErr, v.expRd, v.expWr});
    #1;
    checkOutput($sformatf("vec%0d_waitrequest", n), {31'd0, aWait}, 32'd0);
    @(posedge clk);
    #1;
    aRead = 1'b0; aWrite = 1'b0;
    popAndCompare(aRdata, aErr, aRdCnt, aWrCnt);
  endtask

  // One transfer on instance B held until accepted, counting stall cycles.
  task automatic applyStimulusB(input string tag, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int expWaits,
                                input logic [31:0] expData, input logic expErr,
                                input logic [31:0] expRd, input logic [31:0] expWr);
    int  waits = 0;
    bit  done  = 1'b0;
    @(negedge clk);
    bRead = rd; bWrite = wr; bAddr = addr; bWdata = wdata; bBe = be;
    sbQ.push_back('{tag, expData, expErr, expRd, expWr});
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bWait) begin
        waits++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bRead = 1'b0; bWrite = 1'b0;
    checkOutput({tag, "_wait_cycles"}, 32'(waits), 32'(expWaits));
    popAndCompare(bRdata, bErr, bRdCnt, bWrCnt);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //          rst   rd    wr    addr          wdata         be    expData       err   rd     wr
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'hBFC00000, 32'h00000000, 4'hF, 32'h00000000, 1'b0, 32'd0, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'hBFC00004, 32'h00F10000, 4'hF, 32'h00000000, 1'b0, 32'd0, 32'd2};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'hBFC00004, 32'h00000000, 4'hF, 32'h00F10000, 1'b0, 32'd1, 32'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'hBFC00008, 32'h00000000, 4'hF, 32'h00F10000, 1'b0, 32'd1, 32'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'hBFC00008, 32'hAABBCCDD, 4'h2, 32'h00F10000, 1'b0, 32'd1, 32'd4};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'hBFC00008, 32'h00000000, 4'hF, 32'h0000CC00, 1'b0, 32'd2, 32'd4};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'hBFC0000C, 32'h12345678, 4'hF, 32'h0000CC00, 1'b0, 32'd2, 32'd5};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'hBFC0000C, 32'h00000000, 4'hF, 32'h12345678, 1'b0, 32'd3, 32'd5};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'hBFC00004, 32'h00000000, 4'hC, 32'h00F15678, 1'b0, 32'd4, 32'd5};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'hBFC0000C, 32'h00000000, 4'h0, 32'h00F15678, 1'b0, 32'd5, 32'd5};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'hBFC0000C, 32'hFFFFFFFF, 4'h0, 32'h00F15678, 1'b0, 32'd5, 32'd6};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'hBFC0000C, 32'h00000000, 4'hF, 32'h12345678, 1'b0, 32'd6, 32'd6};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 4'hF, 32'h00000000, 1'b0, 32'd7, 32'd6};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'hBFC0000C, 32'h00000000, 4'hF, 32'h12345678, 1'b0, 32'd8, 32'd6};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 32'hBFC00040, 32'h00000000, 4'hF, 32'h00000000, 1'b1, 32'd9, 32'd6};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'hBFC00040, 32'hDEADBEEF, 4'hF, 32'h00000000, 1'b1, 32'd9, 32'd7};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 32'hBFC00000, 32'h00000000, 4'hF, 32'h00000000, 1'b1, 32'd10, 32'd7};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 32'hBFC0000D, 32'h00000000, 4'hF, 32'h12345678, 1'b1, 32'd1, 32'd0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 32'hBFC0000C, 32'h00000000, 4'hF, 32'h12345678, 1'b0, 32'd1, 32'd0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 32'hBFC00008, 32'h00000001, 4'hF, 32'h12345678, 1'b1, 32'd1, 32'd1};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 32'hBFC00008, 32'h00000000, 4'hF, 32'h00000001, 1'b1, 32'd2, 32'd1};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 32'hBFC0000C, 32'h00000000, 4'hF, 32'h12345678, 1'b0, 32'd1, 32'd0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 4'h3, 32'h12340000, 1'b0, 32'd2, 32'd0};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 32'hBFC0003C, 32'hCAFEF00D, 4'hF, 32'h12340000, 1'b0, 32'd2, 32'd1};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 32'hBFC0003C, 32'h00000000, 4'hF, 32'hCAFEF00D, 1'b0, 32'd3, 32'd1};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 32'hBFBFFFFC, 32'h00000000, 4'hF, 32'h00000000, 1'b1, 32'd4, 32'd1};

    // Power-on reset of both instances and check of the reset state.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("resetA_waitrequest", {31'd0, aWait}, 32'd0);
    checkOutput("resetA_readdata", aRdata, 32'h0);
    checkOutput("resetA_err", {31'd0, aErr}, 32'd0);
    checkOutput("resetA_rd_count", aRdCnt, 32'd0);
    checkOutput("resetA_wr_count", aWrCnt, 32'd0);
    checkOutput("resetB_waitrequest", {31'd0, bWait}, 32'd0);
    rstA = 1'b0;
    rstB = 1'b0;

    for (int n = 0; n < 26; n++) applyStimulus(vecs[n], n);

    // Stored images in big-endian lane order.
    checkOutput("memA_word1", dutA.mem_q[1], 32'h0000F100);
    checkOutput("memA_word2", dutA.mem_q[2], 32'h01000000);
    checkOutput("memA_word15", dutA.mem_q[15], 32'h0DF0FECA);

    // Instance B: three wait states per transfer, straight lane mapping.
    applyStimulusB("b_w0", 1'b0, 1'b1, 32'hBFC00004, 32'h00000000, 4'hF, 3, 32'h00000000, 1'b0, 32'd0, 32'd1);
    applyStimulusB("b_w1", 1'b0, 1'b1, 32'hBFC00004, 32'hAABBCCDD, 4'h2, 3, 32'h00000000, 1'b0, 32'd0, 32'd2);
    checkOutput("memB_word1", dutB.mem_q[1], 32'h0000CC00);
    applyStimulusB("b_r1", 1'b1, 1'b0, 32'hBFC00004, 32'h00000000, 4'hF, 3, 32'h0000CC00, 1'b0, 32'd1, 32'd2);
    applyStimulusB("b_w2", 1'b0, 1'b1, 32'hBFC00000, 32'h5A5A0001, 4'hF, 3, 32'h0000CC00, 1'b0, 32'd1, 32'd3);
    applyStimulusB("b_r2", 1'b1, 1'b0, 32'hBFC00000, 32'h00000000, 4'hF, 3, 32'h5A5A0001, 1'b0, 32'd2, 32'd3);

    // Request dropped mid-stall: nothing completes, next request waits the full count.
    @(negedge clk);
    bRead = 1'b1; bAddr = 32'hBFC00004; bBe = 4'hF;
    #1;
    checkOutput("b_abandon_stall", {31'd0, bWait}, 32'd1);
    @(posedge clk);
    #1;
    bRead = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b_abandon_rd_count", bRdCnt, 32'd2);
    checkOutput("b_abandon_readdata", bRdata, 32'h5A5A0001);
    applyStimulusB("b_r3", 1'b1, 1'b0, 32'hBFC00004, 32'h00000000, 4'hF, 3, 32'h0000CC00, 1'b0, 32'd3, 32'd3);
    applyStimulusB("b_w3", 1'b0, 1'b1, 32'hBFC00008, 32'h00000000, 4'hF, 3, 32'h0000CC00, 1'b0, 32'd3, 32'd4);

    // Reset asserted two cycles into a stalled write: the write must not land.
    @(negedge clk);
    bWrite = 1'b1; bAddr = 32'hBFC00008; bWdata = 32'h11111111; bBe = 4'hF;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("b_rststall_pre", {31'd0, bWait}, 32'd1);
    rstB = 1'b1;
    #1;
    checkOutput("b_rststall_waitrequest", {31'd0, bWait}, 32'd0);
    bWrite = 1'b0;
    @(negedge clk);
    checkOutput("b_rststall_wr_count", bWrCnt, 32'd0);
    checkOutput("b_rststall_rd_count", bRdCnt, 32'd0);
    rstB = 1'b0;
    checkOutput("memB_word2", dutB.mem_q[2], 32'h00000000);
    applyStimulusB("b_r4", 1'b1, 1'b0, 32'hBFC00008, 32'h00000000, 4'hF, 3, 32'h00000000, 1'b0, 32'd1, 32'd0);

    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
